// File: rtl/ldpc_pkg.sv
// Shared definitions for the LDPC decoder control path: controller state
// encoding and the default phase lengths also used by the VNU/CNU array wrappers.
package ldpc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_VNU   = 3'd2,
        ST_CHECK = 3'd3,
        ST_CNU   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int DEF_MAX_ITER = 10;
    localparam int DEF_ITER_W   = 4;
    localparam int DEF_LOAD_CYC = 4;
    localparam int DEF_VNU_CYC  = 2;
    localparam int DEF_CNU_CYC  = 2;

    // The timer holds (length - 1), so the longest phase sets its width.
    function automatic int timer_width(input int len_a, input int len_b, input int len_c);
        int longest;
        longest = (len_a > len_b) ? len_a : len_b;
        longest = (longest > len_c) ? longest : len_c;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

endpackage

// File: rtl/ldpc_iter_ctrl_phase_timer.sv
// Down-counter shared by all timed phases; reloaded on every state entry and
// flags the final cycle of the phase.
module phase_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] count_r;

    // Load on phase entry, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != {CNT_W{1'b0}}) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/ldpc_iter_ctrl.sv
// LDPC iteration controller: LLR load, alternating VNU/CNU phases with a parity
// check after each VNU pass, early exit on zero syndrome, cap, or abort.
module ldpc_iter_ctrl
    import ldpc_pkg::*;
#(
    parameter int MAX_ITER = DEF_MAX_ITER,
    parameter int ITER_W   = DEF_ITER_W,
    parameter int LOAD_CYC = DEF_LOAD_CYC,
    parameter int VNU_CYC  = DEF_VNU_CYC,
    parameter int CNU_CYC  = DEF_CNU_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              syndrome_zero,
    output logic              busy,
    output logic              llr_load,
    output logic              vnu_en,
    output logic              cnu_en,
    output logic              done,
    output logic              success,
    output logic [ITER_W-1:0] iter_count,
    output logic [2:0]        phase
);

    localparam int TMR_W = timer_width(LOAD_CYC, VNU_CYC, CNU_CYC);
    localparam logic [TMR_W-1:0]  LOAD_LEN = TMR_W'(LOAD_CYC - 1);
    localparam logic [TMR_W-1:0]  VNU_LEN  = TMR_W'(VNU_CYC - 1);
    localparam logic [TMR_W-1:0]  CNU_LEN  = TMR_W'(CNU_CYC - 1);
    localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

    state_t            state_r;
    state_t            state_s;
    logic [ITER_W-1:0] iter_r;
    logic [ITER_W-1:0] iter_s;
    logic              success_r;
    logic              success_s;
    logic              tmr_load_s;
    logic [TMR_W-1:0]  tmr_val_s;
    logic              tmr_expire_s;

    logic              busy_r;
    logic              llr_load_r;
    logic              vnu_en_r;
    logic              cnu_en_r;
    logic              done_r;
    logic [2:0]        phase_r;

    phase_timer #(
        .CNT_W (TMR_W)
    ) u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .expire   (tmr_expire_s)
    );

    // Next-state, iteration count and convergence flag; abort outranks the
    // parity result, which outranks phase-timer expiry.
    always_comb begin
        state_s   = state_r;
        iter_s    = iter_r;
        success_s = success_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s   = ST_LOAD;
                    iter_s    = {ITER_W{1'b0}};
                    success_s = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_s = ST_DONE;
                end else if (tmr_expire_s) begin
                    state_s = ST_VNU;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_VNU: begin
                if (abort) begin
                    state_s = ST_DONE;
                end else if (tmr_expire_s) begin
                    state_s = ST_CHECK;
                    iter_s  = (iter_r >= ITER_MAX) ? iter_r : (iter_r + ITER_W'(1));
                end else begin
                    state_s = ST_VNU;
                end
            end
            ST_CHECK: begin
                if (abort) begin
                    state_s   = ST_DONE;
                    success_s = 1'b0;
                end else if (syndrome_zero) begin
                    state_s   = ST_DONE;
                    success_s = 1'b1;
                end else if (iter_r >= ITER_MAX) begin
                    state_s   = ST_DONE;
                    success_s = 1'b0;
                end else begin
                    state_s = ST_CNU;
                end
            end
            ST_CNU: begin
                if (abort) begin
                    state_s = ST_DONE;
                end else if (tmr_expire_s) begin
                    state_s = ST_VNU;
                end else begin
                    state_s = ST_CNU;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Reload the phase timer whenever a new state is entered.
    always_comb begin
        tmr_load_s = (state_s != state_r);
        case (state_s)
            ST_LOAD: tmr_val_s = LOAD_LEN;
            ST_VNU:  tmr_val_s = VNU_LEN;
            ST_CNU:  tmr_val_s = CNU_LEN;
            default: tmr_val_s = {TMR_W{1'b0}};
        endcase
    end

    // Controller state, iteration count and convergence flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            iter_r    <= {ITER_W{1'b0}};
            success_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            iter_r    <= iter_s;
            success_r <= success_s;
        end
    end

    // Strobes are decoded from the next state so they line up with state_r.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r     <= 1'b0;
            llr_load_r <= 1'b0;
            vnu_en_r   <= 1'b0;
            cnu_en_r   <= 1'b0;
            done_r     <= 1'b0;
            phase_r    <= 3'd0;
        end else begin
            busy_r     <= (state_s != ST_IDLE);
            llr_load_r <= (state_s == ST_LOAD);
            vnu_en_r   <= (state_s == ST_VNU);
            cnu_en_r   <= (state_s == ST_CNU);
            done_r     <= (state_s == ST_DONE);
            phase_r    <= state_s;
        end
    end

    assign busy       = busy_r;
    assign llr_load   = llr_load_r;
    assign vnu_en     = vnu_en_r;
    assign cnu_en     = cnu_en_r;
    assign done       = done_r;
    assign success    = success_r;
    assign iter_count = iter_r;
    assign phase      = phase_r;

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Randomized bench for ldpc_iter_ctrl: a phase-list model predicts every cycle,
// and a done-event scoreboard checks each completed decode.
module tb_ldpc_iter_ctrl;

    localparam int MAX_ITER = 10;
    localparam int ITER_W   = 4;
    localparam int LOAD_CYC = 4;
    localparam int VNU_CYC  = 2;
    localparam int CNU_CYC  = 2;

    localparam int P_IDLE  = 0;
    localparam int P_LOAD  = 1;
    localparam int P_VNU   = 2;
    localparam int P_CHECK = 3;
    localparam int P_CNU   = 4;
    localparam int P_DONE  = 5;
    localparam int MAXC    = 4096;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              syndrome_zero = 1'b0;
    logic              busy;
    logic              llr_load;
    logic              vnu_en;
    logic              cnu_en;
    logic              done;
    logic              success;
    logic [ITER_W-1:0] iter_count;
    logic [2:0]        phase;

    typedef struct {
        int cyc;
        int succ;
        int iter;
    } exp_t;

    exp_t sb_q[$];
    int   exp_phase [MAXC];
    int   exp_iter  [MAXC];
    int   exp_succ  [MAXC];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    ldpc_iter_ctrl #(
        .MAX_ITER (MAX_ITER),
        .ITER_W   (ITER_W),
        .LOAD_CYC (LOAD_CYC),
        .VNU_CYC  (VNU_CYC),
        .CNU_CYC  (CNU_CYC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .syndrome_zero (syndrome_zero),
        .busy          (busy),
        .llr_load      (llr_load),
        .vnu_en        (vnu_en),
        .cnu_en        (cnu_en),
        .done          (done),
        .success       (success),
        .iter_count    (iter_count),
        .phase         (phase)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    // Monitor: per-cycle outputs against the model, plus scoreboard pop on done.
    int   m_c;
    int   m_p;
    exp_t m_e;
    always @(negedge clk) begin
        if (mon_en && cyc < MAXC) begin
            m_c = cyc;
            m_p = exp_phase[m_c];
            chk("phase",      int'(phase),      m_p);
            chk("busy",       int'(busy),       (m_p != P_IDLE)  ? 1 : 0);
            chk("llr_load",   int'(llr_load),   (m_p == P_LOAD)  ? 1 : 0);
            chk("vnu_en",     int'(vnu_en),     (m_p == P_VNU)   ? 1 : 0);
            chk("cnu_en",     int'(cnu_en),     (m_p == P_CNU)   ? 1 : 0);
            chk("done",       int'(done),       (m_p == P_DONE)  ? 1 : 0);
            chk("success",    int'(success),    exp_succ[m_c]);
            chk("iter_count", int'(iter_count), exp_iter[m_c]);
            if (done) begin
                chk("sb_has_entry", (sb_q.size() > 0) ? 1 : 0, 1);
                if (sb_q.size() > 0) begin
                    m_e = sb_q.pop_front();
                    chk("sb_done_cycle", m_c, m_e.cyc);
                    chk("sb_success", int'(success), m_e.succ);
                    chk("sb_iter", int'(iter_count), m_e.iter);
                end
            end
        end
    end

    // One decode starting in the current cycle.  k = converging pass (0 or
    // > MAX_ITER: never), a = abort offset, r = reset offset (0 = none).
    task automatic run_decode(input int k, input int a, input int r, input int gap);
        int tl[$];
        int pass_of[$];
        int s, n, succ, run, p;
        bit rst_cut;
        s = cyc;
        if (s + 80 >= MAXC) return;
        for (int i = 0; i < LOAD_CYC; i++) begin
            tl.push_back(P_LOAD); pass_of.push_back(0);
        end
        succ = 0;
        for (int ps = 1; ps <= MAX_ITER; ps++) begin
            for (int i = 0; i < VNU_CYC; i++) begin
                tl.push_back(P_VNU); pass_of.push_back(0);
            end
            tl.push_back(P_CHECK); pass_of.push_back(ps);
            if (ps == k) begin
                succ = 1;
                break;
            end
            if (ps == MAX_ITER) break;
            for (int i = 0; i < CNU_CYC; i++) begin
                tl.push_back(P_CNU); pass_of.push_back(0);
            end
        end
        tl.push_back(P_DONE); pass_of.push_back(0);
        if (a >= 1 && a <= tl.size() && tl[a-1] != P_DONE) begin
            while (tl.size() > a) begin
                void'(tl.pop_back()); void'(pass_of.pop_back());
            end
            tl.push_back(P_DONE); pass_of.push_back(0);
            succ = 0;
        end
        rst_cut = (r >= 1 && r <= tl.size());
        if (rst_cut) begin
            while (tl.size() > r) begin
                void'(tl.pop_back()); void'(pass_of.pop_back());
            end
        end
        n = tl.size();
        run = 0;
        for (int i = 1; i <= n; i++) begin
            exp_phase[s+i] = tl[i-1];
            if (tl[i-1] == P_CHECK) run++;
            exp_iter[s+i] = run;
            exp_succ[s+i] = (tl[i-1] == P_DONE) ? succ : 0;
        end
        for (int c = s + n + 1; c < MAXC; c++) begin
            exp_phase[c] = P_IDLE;
            exp_iter[c]  = rst_cut ? 0 : run;
            exp_succ[c]  = rst_cut ? 0 : succ;
        end
        if (!rst_cut) sb_q.push_back('{s + n, succ, run});

        start = 1'b1;
        rst = 1'b0;
        abort = 1'($urandom_range(0, 1));
        syndrome_zero = 1'($urandom_range(0, 1));
        for (int i = 1; i <= n; i++) begin
            @(posedge clk); #1;
            p = tl[i-1];
            start = ($urandom_range(0, 3) == 0);
            syndrome_zero = (p == P_CHECK) ? (pass_of[i-1] == k) : 1'($urandom_range(0, 1));
            abort = (i == a) ? 1'b1 : ((p == P_DONE) ? 1'($urandom_range(0, 1)) : 1'b0);
            rst = rst_cut && (i == r);
        end
        @(posedge clk); #1;
        start = 1'b0;
        rst = 1'b0;
        for (int g = 0; g < gap; g++) begin
            abort = 1'($urandom_range(0, 1));
            syndrome_zero = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int k, a, r;
        for (int c = 0; c < MAXC; c++) begin
            exp_phase[c] = P_IDLE;
            exp_iter[c]  = 0;
            exp_succ[c]  = 0;
        end
        rst = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        syndrome_zero = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        syndrome_zero = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        run_decode(1, 0, 0, 0);
        run_decode(0, 0, 0, 1);
        run_decode(3, 0, 0, 0);
        run_decode(0, 13, 0, 2);
        run_decode(2, 12, 0, 0);
        run_decode(0, 0, 20, 1);
        run_decode(MAX_ITER, 0, 0, 0);

        for (int t = 0; t < 25; t++) begin
            k = $urandom_range(0, MAX_ITER + 1);
            a = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 60) : 0;
            r = (a == 0 && $urandom_range(0, 7) == 0) ? $urandom_range(1, 50) : 0;
            run_decode(k, a, r, $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb_q.size(), 0);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
